// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the mips instruction/data memory responder.
// Optional byte-lane writes are enabled with the MIPS_MEM_BYTE_WE_EN macro.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } mem_state_e;

    localparam logic [31:0] DEF_DM_LIMIT = 32'h0000_00ff;
    localparam logic [31:0] DEF_OOR_DATA = 32'hffff_ffff;

    // Widest byte address handled by word_index; narrower addresses are zero-extended.
    localparam int ADDR_MAX_W = 64;

    function automatic logic [ADDR_MAX_W-1:0] word_index(input logic [ADDR_MAX_W-1:0] addr);
        return addr >> 2;
    endfunction

endpackage

// File: rtl/mips_mem_array.sv
// Word array with one byte-lane write port and one registered synchronous read port.
// Byte lanes are always present here; the top decides whether they are exposed (MIPS_MEM_BYTE_WE_EN).
module mips_mem_array
    import mips_mem_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH),
    parameter int BE_W  = DW / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [BE_W-1:0]  be_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [DW-1:0]    wdata_i,
    input  logic             re_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [DW-1:0]    rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // NOTE: the array itself has no reset so it maps onto plain RAM; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be_i[b]) begin
                    mem[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mips_mem_model.sv
// Instruction/data memory responder for the mips core: 1-cycle fetch, wait-stated data reads.
// Define MIPS_MEM_BYTE_WE_EN to add the DM_BE byte-lane write enable input.
module mips_mem_model
    import mips_mem_pkg::*;
#(
    parameter int              DW       = 32,
    parameter int              AW       = 32,
    parameter int              DEPTH    = 1024,
    parameter int              RD_WAIT  = 0,
    parameter logic [31:0]     DM_LIMIT = DEF_DM_LIMIT,
    parameter logic [DW-1:0]   OOR_DATA = DW'(DEF_OOR_DATA),
    parameter int              CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             Z_R,
    input  logic [AW-1:0]    IM_ADDR,
    output logic [DW-1:0]    IM_DATA,
    input  logic             DM_WE,
    input  logic             DM_RE,
    input  logic [AW-1:0]    DM_ADDR,
`ifdef MIPS_MEM_BYTE_WE_EN
    input  logic [DW/8-1:0]  DM_BE,
`endif
    input  logic [DW-1:0]    DM_WR_DATA,
    output logic [DW-1:0]    DM_RD_DATA,
    output logic             DM_RDY,
    output logic             DM_BUSY,
    output logic [CNT_W-1:0] WR_CNT
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int BE_W  = DW / 8;

    mem_state_e              state_q, state_d;
    logic [2:0]              wait_q, wait_d;
    logic [IDX_W-1:0]        rd_idx_q, rd_idx_d;
    logic                    rd_oor_q, rd_oor_d;
    logic                    oor_sel_q;
    logic [CNT_W-1:0]        wr_cnt_q, wr_cnt_d;

    logic [IDX_W-1:0]        im_idx, dm_idx;
    logic [ADDR_MAX_W-1:0]   dm_word;
    logic                    dm_in_range, accept, wr_acc, rd_acc, rd_load;
    logic [BE_W-1:0]         dm_be;
    logic [DW-1:0]           dm_arr_rdata;

    assign im_idx      = IDX_W'(word_index(ADDR_MAX_W'(IM_ADDR)));
    assign dm_word     = word_index(ADDR_MAX_W'(DM_ADDR));
    assign dm_idx      = dm_word[IDX_W-1:0];
    assign dm_in_range = (ADDR_MAX_W'(DM_ADDR) <= ADDR_MAX_W'(DM_LIMIT))
                      && (dm_word < ADDR_MAX_W'(DEPTH));

`ifdef MIPS_MEM_BYTE_WE_EN
    assign dm_be = DM_BE;
`else
    assign dm_be = '1;
`endif

    // RESP accepts a new request exactly like IDLE; only WAIT shuts the port.
    assign accept = (state_q != WAIT);
    assign wr_acc = accept && DM_WE && dm_in_range;
    assign rd_acc = accept && DM_RE && !DM_WE;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        rd_idx_d = rd_idx_q;
        rd_oor_d = rd_oor_q;
        rd_load  = 1'b0;
        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (rd_acc) begin
                    rd_idx_d = dm_idx;
                    rd_oor_d = !dm_in_range;
                    if (RD_WAIT == 0) begin
                        state_d = RESP;
                        rd_load = 1'b1;
                    end else begin
                        state_d = WAIT;
                        wait_d  = 3'(RD_WAIT - 1);
                    end
                end
            end
            WAIT: begin
                if (wait_q == '0) begin
                    state_d = RESP;
                    rd_load = 1'b1;
                end else begin
                    wait_d = wait_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign wr_cnt_d = (wr_acc && (wr_cnt_q != '1)) ? wr_cnt_q + CNT_W'(1) : wr_cnt_q;

    always_ff @(posedge CLK or negedge Z_R) begin
        if (!Z_R) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            rd_idx_q  <= '0;
            rd_oor_q  <= 1'b0;
            oor_sel_q <= 1'b0;
            wr_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            rd_idx_q  <= rd_idx_d;
            rd_oor_q  <= rd_oor_d;
            wr_cnt_q  <= wr_cnt_d;
            if (rd_load) begin
                oor_sel_q <= rd_oor_d;
            end
        end
    end

    mips_mem_array #(.DW(DW), .DEPTH(DEPTH)) imem (
        .clk     (CLK),
        .rst_n   (Z_R),
        .we_i    (1'b0),
        .be_i    ('0),
        .waddr_i ('0),
        .wdata_i ('0),
        .re_i    (1'b1),
        .raddr_i (im_idx),
        .rdata_o (IM_DATA)
    );

    // The read address is the fresh request when loading in the accept cycle, else the latched one.
    mips_mem_array #(.DW(DW), .DEPTH(DEPTH)) dmem (
        .clk     (CLK),
        .rst_n   (Z_R),
        .we_i    (wr_acc),
        .be_i    (dm_be),
        .waddr_i (dm_idx),
        .wdata_i (DM_WR_DATA),
        .re_i    (rd_load),
        .raddr_i (rd_idx_d),
        .rdata_o (dm_arr_rdata)
    );

    assign DM_RD_DATA = oor_sel_q ? OOR_DATA : dm_arr_rdata;
    assign DM_RDY     = (state_q == RESP);
    assign DM_BUSY    = (state_q == WAIT);
    assign WR_CNT     = wr_cnt_q;

endmodule

// File: tb/tb_mips_mem_model.sv
// Directed bench for mips_mem_model with RD_WAIT=2 and a narrow write counter.
// Also exercises byte-lane writes when MIPS_MEM_BYTE_WE_EN is defined.
module tb_mips_mem_model;

    localparam int CNT_W = 4;

    logic             CLK;
    logic             Z_R;
    logic [31:0]      IM_ADDR;
    logic [31:0]      IM_DATA;
    logic             DM_WE;
    logic             DM_RE;
    logic [31:0]      DM_ADDR;
`ifdef MIPS_MEM_BYTE_WE_EN
    logic [3:0]       DM_BE;
`endif
    logic [31:0]      DM_WR_DATA;
    logic [31:0]      DM_RD_DATA;
    logic             DM_RDY;
    logic             DM_BUSY;
    logic [CNT_W-1:0] WR_CNT;

    int               n_checks;
    int               n_fail;
    int               exp_cnt;

    mips_mem_model #(
        .RD_WAIT (2),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK        (CLK),
        .Z_R        (Z_R),
        .IM_ADDR    (IM_ADDR),
        .IM_DATA    (IM_DATA),
        .DM_WE      (DM_WE),
        .DM_RE      (DM_RE),
        .DM_ADDR    (DM_ADDR),
`ifdef MIPS_MEM_BYTE_WE_EN
        .DM_BE      (DM_BE),
`endif
        .DM_WR_DATA (DM_WR_DATA),
        .DM_RD_DATA (DM_RD_DATA),
        .DM_RDY     (DM_RDY),
        .DM_BUSY    (DM_BUSY),
        .WR_CNT     (WR_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        DM_WE      = 1'b1;
        DM_ADDR    = addr;
        DM_WR_DATA = data;
        tick();
        DM_WE      = 1'b0;
    endtask

    // Issues one read and waits (bounded) for DM_RDY; lat = edges from request to ready, -1 on timeout.
    task automatic read_word(input logic [31:0] addr, output logic [31:0] data, output int lat);
        DM_RE   = 1'b1;
        DM_ADDR = addr;
        tick();
        DM_RE   = 1'b0;
        lat     = 1;
        while (DM_RDY !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        data = DM_RD_DATA;
        if (DM_RDY !== 1'b1) lat = -1;
    endtask

    task automatic bump_cnt();
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    endtask

    task automatic test_reset();
        Z_R     = 1'b1;
        IM_ADDR = 32'h0000_000C;
        #2 Z_R  = 1'b0;
        #1;
        n_checks++; if (IM_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_im_data: got %h expected %h", IM_DATA, 32'h0); end
        n_checks++; if (DM_RD_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected %h", DM_RD_DATA, 32'h0); end
        n_checks++; if (DM_RDY !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", DM_RDY); end
        n_checks++; if (DM_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", DM_BUSY); end
        n_checks++; if (WR_CNT !== '0) begin n_fail++; $display("FAIL reset_wr_cnt: got %0d expected 0", WR_CNT); end
        tick();
        tick();
        n_checks++; if (IM_DATA !== 32'h0) begin n_fail++; $display("FAIL reset_hold_im_data: got %h expected %h", IM_DATA, 32'h0); end
        Z_R = 1'b1;
    endtask

    task automatic test_fetch();
        IM_ADDR = 32'h0000_000C;
        n_checks++; if (IM_DATA !== 32'h0) begin n_fail++; $display("FAIL fetch_latency: got %h expected %h", IM_DATA, 32'h0); end
        tick();
        n_checks++; if (IM_DATA !== 32'h2002_000A) begin n_fail++; $display("FAIL fetch_0c: got %h expected %h", IM_DATA, 32'h2002_000A); end
        IM_ADDR = 32'h0000_0010;
        tick();
        n_checks++; if (IM_DATA !== 32'h8C43_0004) begin n_fail++; $display("FAIL fetch_10: got %h expected %h", IM_DATA, 32'h8C43_0004); end
        IM_ADDR = 32'h0000_000E;
        tick();
        n_checks++; if (IM_DATA !== 32'h2002_000A) begin n_fail++; $display("FAIL fetch_0e_unaligned: got %h expected %h", IM_DATA, 32'h2002_000A); end
    endtask

    task automatic test_write_read();
        write_word(32'h40, 32'h1234_5678);
        bump_cnt();
        n_checks++; if (WR_CNT !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL wr_cnt_first: got %0d expected %0d", WR_CNT, exp_cnt); end
        DM_RE   = 1'b1;
        DM_ADDR = 32'h40;
        tick();
        DM_RE   = 1'b0;
        n_checks++; if ({DM_BUSY, DM_RDY} !== 2'b10) begin n_fail++; $display("FAIL wait1_busy_rdy: got %b expected 10", {DM_BUSY, DM_RDY}); end
        tick();
        n_checks++; if ({DM_BUSY, DM_RDY} !== 2'b10) begin n_fail++; $display("FAIL wait2_busy_rdy: got %b expected 10", {DM_BUSY, DM_RDY}); end
        tick();
        n_checks++; if ({DM_BUSY, DM_RDY} !== 2'b01) begin n_fail++; $display("FAIL resp_busy_rdy: got %b expected 01", {DM_BUSY, DM_RDY}); end
        n_checks++; if (DM_RD_DATA !== 32'h1234_5678) begin n_fail++; $display("FAIL resp_data: got %h expected %h", DM_RD_DATA, 32'h1234_5678); end
        tick();
        n_checks++; if (DM_RDY !== 1'b0) begin n_fail++; $display("FAIL rdy_one_cycle: got %b expected 0", DM_RDY); end
        n_checks++; if (DM_RD_DATA !== 32'h1234_5678) begin n_fail++; $display("FAIL data_hold: got %h expected %h", DM_RD_DATA, 32'h1234_5678); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] data;
        int          lat;
        read_word(32'h100, data, lat);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL oor_read_latency: got %0d expected 3", lat); end
        n_checks++; if (data !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL oor_read_data: got %h expected %h", data, 32'hFFFF_FFFF); end
        write_word(32'h100, 32'hDEAD_BEEF);
        n_checks++; if (WR_CNT !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL oor_write_cnt: got %0d expected %0d", WR_CNT, exp_cnt); end
        n_checks++; if (dut.dmem.mem[64] !== 32'h5A5A_5A5A) begin n_fail++; $display("FAIL oor_write_dropped: got %h expected %h", dut.dmem.mem[64], 32'h5A5A_5A5A); end
        write_word(32'hFC, 32'hCAFE_F00D);
        bump_cnt();
        read_word(32'hFF, data, lat);
        n_checks++; if (data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL limit_edge_data: got %h expected %h", data, 32'hCAFE_F00D); end
        n_checks++; if (WR_CNT !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL limit_edge_cnt: got %0d expected %0d", WR_CNT, exp_cnt); end
        tick();
    endtask

    task automatic test_collision();
        logic [31:0] data;
        int          lat;
        DM_WE      = 1'b1;
        DM_RE      = 1'b1;
        DM_ADDR    = 32'h20;
        DM_WR_DATA = 32'h0BAD_F00D;
        tick();
        DM_WE      = 1'b0;
        DM_RE      = 1'b0;
        bump_cnt();
        n_checks++; if ({DM_BUSY, DM_RDY} !== 2'b00) begin n_fail++; $display("FAIL collision_state: got %b expected 00", {DM_BUSY, DM_RDY}); end
        n_checks++; if (WR_CNT !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL collision_cnt: got %0d expected %0d", WR_CNT, exp_cnt); end
        tick();
        tick();
        n_checks++; if (DM_RDY !== 1'b0) begin n_fail++; $display("FAIL collision_no_rdy: got %b expected 0", DM_RDY); end
        read_word(32'h20, data, lat);
        n_checks++; if (data !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL collision_write_done: got %h expected %h", data, 32'h0BAD_F00D); end
        tick();
    endtask

    task automatic test_busy_ignore();
        logic [31:0] data;
        int          lat;
        int          pulses;
        logic [31:0] got;
        DM_RE   = 1'b1;
        DM_ADDR = 32'h40;
        tick();
        DM_RE      = 1'b1;
        DM_WE      = 1'b1;
        DM_ADDR    = 32'h44;
        DM_WR_DATA = 32'h7777_7777;
        tick();
        DM_RE  = 1'b0;
        DM_WE  = 1'b0;
        pulses = 0;
        got    = 32'h0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (DM_RDY === 1'b1) begin
                pulses++;
                got = DM_RD_DATA;
            end
        end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL busy_single_rdy: got %0d expected 1", pulses); end
        n_checks++; if (got !== 32'h1234_5678) begin n_fail++; $display("FAIL busy_first_data: got %h expected %h", got, 32'h1234_5678); end
        n_checks++; if (WR_CNT !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL busy_write_ignored_cnt: got %0d expected %0d", WR_CNT, exp_cnt); end
        read_word(32'h44, data, lat);
        n_checks++; if (data !== 32'h0) begin n_fail++; $display("FAIL busy_write_ignored_mem: got %h expected %h", data, 32'h0); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] data;
        int          lat;
        read_word(32'h40, data, lat);
        n_checks++; if (data !== 32'h1234_5678) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", data, 32'h1234_5678); end
        DM_RE   = 1'b1;
        DM_ADDR = 32'h20;
        tick();
        DM_RE   = 1'b0;
        n_checks++; if ({DM_BUSY, DM_RDY} !== 2'b10) begin n_fail++; $display("FAIL b2b_accepted: got %b expected 10", {DM_BUSY, DM_RDY}); end
        tick();
        tick();
        n_checks++; if (DM_RDY !== 1'b1) begin n_fail++; $display("FAIL b2b_second_rdy: got %b expected 1", DM_RDY); end
        n_checks++; if (DM_RD_DATA !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL b2b_second_data: got %h expected %h", DM_RD_DATA, 32'h0BAD_F00D); end
        tick();
    endtask

`ifdef MIPS_MEM_BYTE_WE_EN
    task automatic test_byte_we();
        logic [31:0] data;
        int          lat;
        DM_BE = 4'hF;
        write_word(32'h0, 32'hAABB_CCDD);
        bump_cnt();
        DM_BE = 4'b0101;
        write_word(32'h0, 32'h1122_3344);
        bump_cnt();
        DM_BE = 4'hF;
        read_word(32'h0, data, lat);
        n_checks++; if (data !== 32'hAA22_CC44) begin n_fail++; $display("FAIL byte_lanes: got %h expected %h", data, 32'hAA22_CC44); end
        DM_BE = 4'h0;
        write_word(32'h0, 32'h9999_9999);
        bump_cnt();
        DM_BE = 4'hF;
        read_word(32'h0, data, lat);
        n_checks++; if (data !== 32'hAA22_CC44) begin n_fail++; $display("FAIL byte_none: got %h expected %h", data, 32'hAA22_CC44); end
        n_checks++; if (WR_CNT !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL byte_cnt: got %0d expected %0d", WR_CNT, exp_cnt); end
        tick();
    endtask
`endif

    task automatic test_wr_cnt_sat();
        for (int i = 0; i < 20; i++) begin
            write_word(32'h08, 32'h100 + i);
            bump_cnt();
        end
        n_checks++; if (WR_CNT !== CNT_W'(exp_cnt)) begin n_fail++; $display("FAIL wr_cnt_saturate: got %0d expected %0d", WR_CNT, exp_cnt); end
        n_checks++; if (WR_CNT !== '1) begin n_fail++; $display("FAIL wr_cnt_all_ones: got %0d expected %0d", WR_CNT, (1 << CNT_W) - 1); end
    endtask

    task automatic test_reset_abort();
        int pulses;
        DM_RE   = 1'b1;
        DM_ADDR = 32'h40;
        tick();
        DM_RE   = 1'b0;
        #2 Z_R  = 1'b0;
        #1;
        n_checks++; if ({DM_BUSY, DM_RDY} !== 2'b00) begin n_fail++; $display("FAIL abort_busy_rdy: got %b expected 00", {DM_BUSY, DM_RDY}); end
        n_checks++; if (DM_RD_DATA !== 32'h0) begin n_fail++; $display("FAIL abort_rd_data: got %h expected %h", DM_RD_DATA, 32'h0); end
        n_checks++; if (WR_CNT !== '0) begin n_fail++; $display("FAIL abort_wr_cnt: got %0d expected 0", WR_CNT); end
        n_checks++; if (IM_DATA !== 32'h0) begin n_fail++; $display("FAIL abort_im_data: got %h expected %h", IM_DATA, 32'h0); end
        tick();
        tick();
        Z_R    = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (DM_RDY === 1'b1) pulses++;
        end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_no_rdy: got %0d expected 0", pulses); end
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        exp_cnt    = 0;
        Z_R        = 1'b1;
        IM_ADDR    = 32'h0;
        DM_WE      = 1'b0;
        DM_RE      = 1'b0;
        DM_ADDR    = 32'h0;
        DM_WR_DATA = 32'h0;
`ifdef MIPS_MEM_BYTE_WE_EN
        DM_BE      = 4'hF;
`endif
        dut.imem.mem[3]  <= 32'h2002_000A;
        dut.imem.mem[4]  <= 32'h8C43_0004;
        dut.dmem.mem[17] <= 32'h0;
        dut.dmem.mem[64] <= 32'h5A5A_5A5A;

        test_reset();
        test_fetch();
        test_write_read();
        test_out_of_range();
        test_collision();
        test_busy_ignore();
        test_back_to_back();
`ifdef MIPS_MEM_BYTE_WE_EN
        test_byte_we();
`endif
        test_wr_cnt_sat();
        test_reset_abort();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
